// File: rtl/fetch_pf.sv
// fetch_pf: instruction prefetcher with a DEPTH-entry queue between a
// single-outstanding memory port and the decode-side handshake.
// Optional feature: define FETCH_PF_BYPASS_EN to let a response arriving
// while the queue is empty drive out_* in the same cycle.
module fetch_pf #(
    parameter int unsigned       PC_W     = 16,
    parameter int unsigned       INSN_W   = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter int unsigned       PC_INC   = 2,
    parameter logic [INSN_W-1:0] NOP_WORD = INSN_W'(16'h0800)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [INSN_W-1:0] out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_next,
    output logic              out_err,
    output logic              mem_rd,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_done,
    input  logic [INSN_W-1:0] mem_data,
    input  logic              mem_err,
    output logic              halted
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [PC_W-1:0] INC_C   = PC_W'(PC_INC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] drop_pc_q, drop_pc_d;   // address of the request being drained in DROP
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INSN_W-1:0] insn_mem [DEPTH];
    logic              err_mem  [DEPTH];

    logic head_valid;
    logic bypass;
    logic take;
    logic push;
    logic pop;

    // Output side: queue head, same-cycle bypass, or the idle NOP word
    always_comb begin
        head_valid = (count_q != '0);
`ifdef FETCH_PF_BYPASS_EN
        bypass = rst && (state_q == S_REQ) && mem_done && !redirect && !head_valid;
`else
        bypass = 1'b0;
`endif
        out_valid = head_valid || bypass;
        out_pc    = '0;
        out_insn  = NOP_WORD;
        out_err   = 1'b0;
        if (bypass) begin
            out_pc   = fetch_pc_q;
            out_insn = mem_err ? '0 : mem_data;
            out_err  = mem_err;
        end else if (head_valid) begin
            out_pc   = pc_mem[rd_ptr_q];
            out_insn = err_mem[rd_ptr_q] ? '0 : insn_mem[rd_ptr_q];
            out_err  = err_mem[rd_ptr_q];
        end
        out_pc_next = out_pc + INC_C;

        // redirect wins over both queue operations; a bypassed word that is
        // accepted downstream never enters the queue
        take   = (state_q == S_REQ) && mem_done && !redirect;
        push   = take && !(bypass && out_ready);
        pop    = head_valid && out_ready && !redirect;

        // rst gate keeps the port quiet while the state flop sits at REQ in reset
        mem_rd   = rst && ((state_q == S_REQ) || (state_q == S_DROP));
        mem_addr = (state_q == S_DROP) ? drop_pc_q : fetch_pc_q;
        halted   = (state_q == S_HALT);
    end

    // Next-state, fetch address and queue pointer update
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_pc_d  = drop_pc_q;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc;
            case (state_q)
                S_REQ: begin
                    // a response landing in the redirect cycle is simply dropped
                    state_d   = mem_done ? S_REQ : S_DROP;
                    drop_pc_d = fetch_pc_q;
                end
                // retarget only; the old request still has to complete, and
                // once it does there is nothing left to drain
                S_DROP:  state_d = mem_done ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
                S_REQ: begin
                    if (mem_done) begin
                        fetch_pc_d = fetch_pc_q + INC_C;
                        if (mem_err || (mem_data == '0)) state_d = S_HALT;
                        else if (count_d < DEPTH_C)       state_d = S_REQ;
                        else                              state_d = S_IDLE;
                    end
                end
                S_DROP:  if (mem_done) state_d = S_REQ;
                default: state_d = S_HALT;
            endcase
        end
    end

    // Control state; reset parks in REQ so fetch starts on the first free cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            drop_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_pc_q  <= drop_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only visible through count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            insn_mem[wr_ptr_q] <= mem_data;
            err_mem[wr_ptr_q]  <= mem_err;
        end
    end

endmodule

// File: tb/tb_fetch_pf.sv
// tb_fetch_pf: randomized bench for fetch_pf. The program model maps every
// address to a word; each restart point (reset/redirect) queues the expected
// in-order instruction stream, and a monitor scores every accepted output.
module tb_fetch_pf;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INSN_W = 16;
    localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [INSN_W-1:0] out_insn;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   out_pc_next;
    logic              out_err;
    logic              mem_rd;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_done = 1'b0;
    logic [INSN_W-1:0] mem_data = '0;
    logic              mem_err = 1'b0;
    logic              halted;

    fetch_pf #(.PC_W(PC_W), .INSN_W(INSN_W), .DEPTH(4), .RESET_PC(32'h100),
               .PC_INC(2), .NOP_WORD(16'h0800)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_insn(out_insn),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .out_err(out_err),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_done(mem_done),
        .mem_data(mem_data), .mem_err(mem_err), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] insn;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] halt_addr = NONE;
    logic [31:0] err_addr  = NONE;
    logic [31:0] slow_addr = NONE;
    bit          rand_wait = 1'b0;
    int          wait_max  = 0;
    logic [15:0] last_insn = '1;
    logic        last_err  = 1'b0;

    // program image: a halt word, an error location, else pc/2 + 0x1000
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == err_addr)  return 16'hDEAD;
        if (a == halt_addr) return 16'h0000;
        return 16'((a >> 1) + 32'h1000);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic expired(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // expected stream from a restart point up to and including a stop entry
    task automatic gen_segment(input logic [31:0] start);
        exp_t e;
        expq.delete();
        for (int k = 0; k < 64; k++) begin
            e.pc   = start + 32'(2 * k);
            e.err  = (e.pc == err_addr);
            e.insn = e.err ? 16'h0000 : mem_word(e.pc);
            expq.push_back(e);
            if (e.err || e.insn == 16'h0000) break;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect    = 1'b1;
        redirect_pc = t;
        out_ready   = 1'b0;
        gen_segment(t);
        tick();
        redirect = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},   32'(out_valid),  32'h0);
        check({tag, "_out_insn"},    32'(out_insn),   32'h0800);
        check({tag, "_out_err"},     32'(out_err),    32'h0);
        check({tag, "_halted"},      32'(halted),     32'h0);
        check({tag, "_out_pc"},      out_pc,          32'h0);
        check({tag, "_out_pc_next"}, out_pc_next,     32'h2);
        check({tag, "_mem_rd"},      32'(mem_rd),     32'h0);
    endtask

    // memory: one request at a time, optional wait states, address must hold
    initial begin : responder
        int          wcnt;
        bit          busy;
        logic [31:0] lat_addr;
        busy = 1'b0;
        wcnt = 0;
        lat_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_rd) begin
                busy     = 1'b0;
                mem_done = 1'b0;
            end else begin
                if (!busy) begin
                    busy     = 1'b1;
                    lat_addr = mem_addr;
                    if (mem_addr == slow_addr) wcnt = 3;
                    else if (rand_wait)        wcnt = int'($urandom_range(0, wait_max));
                    else                       wcnt = 0;
                end else begin
                    check("mem_addr_stable", mem_addr, lat_addr);
                end
                if (wcnt == 0) begin
                    mem_done = 1'b1;
                    mem_data = mem_word(lat_addr);
                    mem_err  = (lat_addr == err_addr);
                    busy     = 1'b0;
                end else begin
                    mem_done = 1'b0;
                    mem_data = $urandom();
                    mem_err  = 1'b0;
                    wcnt--;
                end
            end
        end
    end

    // scoreboard monitor: every accepted entry must be the next expected one
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && !redirect) begin
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_extra: got pc %0h, required no entry", out_pc);
                end else begin
                    mon_e = expq.pop_front();
                    last_insn = out_insn;
                    last_err  = out_err;
                    if (out_pc !== mon_e.pc || out_insn !== mon_e.insn ||
                        out_err !== mon_e.err || out_pc_next !== mon_e.pc + 32'd2) begin
                        nerr++;
                        $display("FAIL sb_entry: got pc %0h next %0h insn %0h err %0b, required pc %0h next %0h insn %0h err %0b",
                                 out_pc, out_pc_next, out_insn, out_err,
                                 mon_e.pc, mon_e.pc + 32'd2, mon_e.insn, mon_e.err);
                    end
                end
            end
            if (!out_valid) check("idle_nop", 32'(out_insn), 32'h0800);
            if (halted)     check("halt_no_rd", 32'(mem_rd), 32'h0);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bit seen;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("rst0");

        // release: first request at RESET_PC in the very next cycle
        gen_segment(32'h100);
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("first_mem_rd", 32'(mem_rd), 32'h1);
        check("first_mem_addr", mem_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) expired("first_done");
`ifdef FETCH_PF_BYPASS_EN
        check("first_bypass_valid", 32'(out_valid), 32'h1);
        check("first_bypass_pc", out_pc, 32'h100);
`else
        check("first_lat_valid_n", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("first_lat_valid_n1", 32'(out_valid), 32'h1);
        check("first_lat_pc_n1", out_pc, 32'h100);
`endif
        tick();

        // zero-wait streaming from 0: one instruction per cycle
        do_redirect(32'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        if (!seen) expired("stream_start");
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_pc", out_pc, 32'(2 * k));
            check("stream_insn", 32'(out_insn), 32'h1000 + 32'(k));
            @(negedge clk);
        end
        tick();

        // backpressure: exactly DEPTH pushes, then fetch stops until space
        do_redirect(32'h0);
        n = 0;
        repeat (12) begin
            if (mem_rd && mem_done) n++;
            tick();
        end
        check("stall_pushes", 32'(n), 32'd4);
        check("stall_mem_rd", 32'(mem_rd), 32'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd) begin seen = 1'b1; break; end
            tick();
        end
        if (!seen) expired("stall_resume");
        check("stall_resume_addr", mem_addr, 32'h8);
        repeat (6) tick();

        // redirect while a slow request to 0x6 is pending
        slow_addr = 32'h6;
        do_redirect(32'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd && mem_addr == 32'h6) begin seen = 1'b1; break; end
            tick();
        end
        if (!seen) expired("slow_req");
        tick();
        do_redirect(32'h40);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd && mem_addr != 32'h6) begin seen = 1'b1; break; end
            tick();
        end
        if (!seen) expired("drop_end");
        check("drop_next_addr", mem_addr, 32'h40);
        slow_addr = NONE;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            tick();
        end
        if (!seen) expired("drop_first_out");
        check("drop_first_pc", out_pc, 32'h40);
        repeat (4) tick();

        // halt word at 0xA, then redirect clears halt
        halt_addr = 32'hA;
        do_redirect(32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (!halted || expq.size() != 0); i++) tick();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_drained", 32'(expq.size()), 32'h0);
        check("halt_last_insn", 32'(last_insn), 32'h0);
        repeat (4) tick();
        check("halt_mem_rd", 32'(mem_rd), 32'h0);
        halt_addr = NONE;
        do_redirect(32'h0);
        check("halt_cleared", 32'(halted), 32'h0);
        out_ready = 1'b1;
        repeat (4) tick();

        // memory error at 0x4
        err_addr = 32'h4;
        do_redirect(32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (!halted || expq.size() != 0); i++) tick();
        check("err_halt", 32'(halted), 32'h1);
        check("err_drained", 32'(expq.size()), 32'h0);
        check("err_insn", 32'(last_insn), 32'h0);
        check("err_flag", 32'(last_err), 32'h1);
        err_addr = NONE;

        // reset pulse in the middle of a waiting request
        slow_addr = 32'h22;
        do_redirect(32'h20);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd && mem_addr == 32'h22) begin seen = 1'b1; break; end
            tick();
        end
        if (!seen) expired("rst_slow_req");
        tick();
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        tick();
        tick();
        slow_addr = NONE;
        gen_segment(32'h100);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_rd", 32'(mem_rd), 32'h1);
        check("rst_mid_mem_addr", mem_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) expired("rst_mid_first_out");
        check("rst_mid_first_pc", out_pc, 32'h100);
        tick();

        // randomized segments: wait states, backpressure, halts, errors
        rand_wait = 1'b1;
        wait_max  = 3;
        for (int s = 0; s < 16; s++) begin
            logic [31:0] tgt;
            tgt = 32'($urandom_range(0, 255)) << 1;
            halt_addr = ($urandom_range(0, 2) == 0) ? tgt + (32'($urandom_range(0, 15)) << 1) : NONE;
            err_addr  = ($urandom_range(0, 3) == 0) ? tgt + (32'($urandom_range(0, 15)) << 1) : NONE;
            do_redirect(tgt);
            n = int'($urandom_range(20, 60));
            for (int c = 0; c < n; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        out_ready = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
